// File: rtl/uart_pkg.sv
// Shared UART constants, divisor type and the rounded baud-divisor helper.
package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DIV_W      = 12;
   localparam int UART_FRAC_W     = 4;

   // Standard baud rates.
   localparam int unsigned BAUD_1200   = 1200;
   localparam int unsigned BAUD_2400   = 2400;
   localparam int unsigned BAUD_4800   = 4800;
   localparam int unsigned BAUD_9600   = 9600;
   localparam int unsigned BAUD_19200  = 19200;
   localparam int unsigned BAUD_38400  = 38400;
   localparam int unsigned BAUD_57600  = 57600;
   localparam int unsigned BAUD_115200 = 115200;

   // Divisor {int, frac} at the default widths: cycles per oversample tick.
   typedef logic [UART_DIV_W+UART_FRAC_W-1:0] baud_div_t;

   // round(clk * 2^frac_w / (baud * os)), used for the reset divisor.
   function automatic longint unsigned calc_baud_div(input longint unsigned clk_hz,
                                                     input longint unsigned baud,
                                                     input longint unsigned os,
                                                     input longint unsigned frac_w);
      longint unsigned den;
      den = baud * os;
      return ((clk_hz << frac_w) + (den >> 1)) / den;
   endfunction

endpackage

// File: rtl/uart_baud_chan.sv
// One baud channel: active divisor copy, fractional os-tick timer and bit/mid-bit strobes.
module uart_baud_chan
   import uart_pkg::*;
#(
   parameter int                         DIV_W      = UART_DIV_W,
   parameter int                         FRAC_W     = UART_FRAC_W,
   parameter int                         OVERSAMPLE = UART_OVERSAMPLE,
   parameter bit                         MID_BIT    = 1'b0,
   parameter logic [DIV_W+FRAC_W-1:0]    RST_DIV    = '0
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   input  logic [DIV_W+FRAC_W-1:0] div_in,
   output logic                    os_stb,
   output logic                    br_stb
);

   localparam int DW   = DIV_W + FRAC_W;
   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);

   logic [DW-1:0]     div_q;
   logic [DIV_W:0]    cnt_q;
   logic [FRAC_W-1:0] acc_q;
   logic [OS_W-1:0]   os_q;

   logic [FRAC_W:0]   sum;
   logic [DIV_W:0]    term;
   logic              tick_end;
   logic              bit_end;
   logic              br_hit;

   // The carry of acc+frac stretches this tick by one cycle; acc only moves at tick end,
   // so the carry stays constant for the whole tick.
   assign sum      = {1'b0, acc_q} + {1'b0, div_q[FRAC_W-1:0]};
   assign term     = {1'b0, div_q[DW-1:FRAC_W]} + {{DIV_W{1'b0}}, sum[FRAC_W]}
                     - {{DIV_W{1'b0}}, 1'b1};
   assign tick_end = (cnt_q == term);
   assign bit_end  = tick_end && (os_q == OS_LAST);

   generate
      if (MID_BIT) begin : g_mid
         assign br_hit = tick_end && (os_q == OS_MID);
      end else begin : g_end
         assign br_hit = bit_end;
      end
   endgenerate

   // Disabled: hold counters cleared and track the shadow; enabled: run, reload only at bit end.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         div_q  <= RST_DIV;
         cnt_q  <= '0;
         acc_q  <= '0;
         os_q   <= '0;
         os_stb <= 1'b0;
         br_stb <= 1'b0;
      end else if (!en) begin
         div_q  <= div_in;
         cnt_q  <= '0;
         acc_q  <= '0;
         os_q   <= '0;
         os_stb <= 1'b0;
         br_stb <= 1'b0;
      end else begin
         cnt_q  <= tick_end ? '0 : cnt_q + 1'b1;
         if (tick_end) begin
            acc_q <= sum[FRAC_W-1:0];
            os_q  <= (os_q == OS_LAST) ? '0 : os_q + 1'b1;
         end
         if (bit_end)
            div_q <= div_in;
         os_stb <= tick_end;
         br_stb <= br_hit;
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: shadow divisor register, integer clamp, one TX and one RX channel.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 10_000_000,
   parameter int DEF_BAUD    = 9600,
   parameter int OVERSAMPLE  = UART_OVERSAMPLE,
   parameter int DIV_W       = UART_DIV_W,
   parameter int FRAC_W      = UART_FRAC_W
)(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    cfg_we,
   input  logic [DIV_W+FRAC_W-1:0] cfg_div,
   output logic [DIV_W+FRAC_W-1:0] cfg_div_q,
   input  logic                    tx_br_en,
   output logic                    tx_br_stb,
   input  logic                    rx_br_en,
   output logic                    rx_os_stb,
   output logic                    rx_br_stb
);

   localparam int DW = DIV_W + FRAC_W;
   localparam logic [DW-1:0] DEF_DIV =
      DW'(calc_baud_div(64'(CLK_FREQ_HZ), 64'(DEF_BAUD), 64'(OVERSAMPLE), 64'(FRAC_W)));
   localparam logic [DW-1:0] DEF_CLAMP =
      (DEF_DIV[DW-1:FRAC_W] < DIV_W'(2)) ? {DIV_W'(2), DEF_DIV[FRAC_W-1:0]} : DEF_DIV;

   logic [DW-1:0] div_nxt;
   logic [DW-1:0] div_eff;
   logic          tx_os_unused;

   // Shadow divisor; readback shows exactly what was written.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cfg_div_q <= DEF_DIV;
      else if (cfg_we) cfg_div_q <= cfg_div;
   end

   // Channels load the value the shadow holds after this edge, so a write landing on a
   // bit boundary already applies to the next bit. Integer part below 2 runs as 2.
   always_comb begin
      div_nxt = cfg_we ? cfg_div : cfg_div_q;
      div_eff = div_nxt;
      if (div_nxt[DW-1:FRAC_W] < DIV_W'(2))
         div_eff[DW-1:FRAC_W] = DIV_W'(2);
   end

   uart_baud_chan #(
      .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OVERSAMPLE),
      .MID_BIT(1'b0), .RST_DIV(DEF_CLAMP)
   ) u_tx (
      .clk(clk), .rstn(rstn), .en(tx_br_en), .div_in(div_eff),
      .os_stb(tx_os_unused), .br_stb(tx_br_stb)
   );

   uart_baud_chan #(
      .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OVERSAMPLE),
      .MID_BIT(1'b1), .RST_DIV(DEF_CLAMP)
   ) u_rx (
      .clk(clk), .rstn(rstn), .en(rx_br_en), .div_in(div_eff),
      .os_stb(rx_os_stb), .br_stb(rx_br_stb)
   );

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: stimulus queues expected strobe cycles, monitor pops them.
module tb_uart_baud_gen;
   import uart_pkg::*;

   logic      clk = 1'b0;
   logic      rstn;
   logic      cfg_we;
   baud_div_t cfg_div;
   baud_div_t cfg_div_q;
   logic      tx_br_en, tx_br_stb;
   logic      rx_br_en, rx_os_stb, rx_br_stb;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;
   bit mon_on = 1'b0;
   int tx_q[$];
   int rxos_q[$];
   int rxbr_q[$];

   uart_baud_gen dut (
      .clk(clk), .rstn(rstn), .cfg_we(cfg_we), .cfg_div(cfg_div), .cfg_div_q(cfg_div_q),
      .tx_br_en(tx_br_en), .tx_br_stb(tx_br_stb),
      .rx_br_en(rx_br_en), .rx_os_stb(rx_os_stb), .rx_br_stb(rx_br_stb)
   );

   always #5 clk = ~clk;

   // Edge counter: after edge k of a test, cyc = base + k.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_val(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp_v);
      end
   endtask

   task automatic take(input string nm, input bit has, input int exp_c);
      n_cmp++;
      if (!has) begin
         n_bad++;
         $display("FAIL %s: pulse at cycle %0d, required no pulse", nm, cyc);
      end else if (exp_c != cyc) begin
         n_bad++;
         $display("FAIL %s: pulse at cycle %0d, required cycle %0d", nm, cyc, exp_c);
      end
   endtask

   task automatic check_empty(input string nm);
      n_cmp++;
      if (tx_q.size() + rxos_q.size() + rxbr_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: missing pulses tx=%0d rxos=%0d rxbr=%0d, required 0/0/0",
                  nm, tx_q.size(), rxos_q.size(), rxbr_q.size());
      end
      tx_q.delete();
      rxos_q.delete();
      rxbr_q.delete();
   endtask

   task automatic write_cfg(input baud_div_t v);
      @(negedge clk);
      cfg_div = v;
      cfg_we  = 1'b1;
      @(negedge clk);
      cfg_we  = 1'b0;
   endtask

   task automatic settle(input string nm);
      repeat (3) @(negedge clk);
      #1 check_empty(nm);
   endtask

   // Monitor: every strobe must match the head of its queue.
   always @(negedge clk) begin : mon
      bit h;
      int e;
      if (mon_on && rstn) begin
         if (tx_br_stb) begin
            h = (tx_q.size() != 0);
            e = h ? tx_q.pop_front() : -1;
            take("tx_br_stb", h, e);
         end
         if (rx_os_stb) begin
            h = (rxos_q.size() != 0);
            e = h ? rxos_q.pop_front() : -1;
            take("rx_os_stb", h, e);
         end
         if (rx_br_stb) begin
            h = (rxbr_q.size() != 0);
            e = h ? rxbr_q.pop_front() : -1;
            take("rx_br_stb", h, e);
         end
      end
   end

   initial begin
      int base;
      int t;
      rstn = 1'b0; cfg_we = 1'b0; cfg_div = '0; tx_br_en = 1'b0; rx_br_en = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // 1: reset defaults
      chk_val("rst_cfg_div_q", int'(cfg_div_q), 'h412);
      chk_val("rst_tx_br_stb", int'(tx_br_stb), 0);
      chk_val("rst_rx_os_stb", int'(rx_os_stb), 0);
      chk_val("rst_rx_br_stb", int'(rx_br_stb), 0);

      // 1: async reset mid-count drops a live strobe and restores the shadow
      write_cfg(16'h040);
      rx_br_en = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk_val("pre_rst_rx_os_stb", int'(rx_os_stb), 1);
      #1 rstn = 1'b0;
      #1 chk_val("async_rst_rx_os_stb", int'(rx_os_stb), 0);
      chk_val("async_rst_cfg_div_q", int'(cfg_div_q), 'h412);
      rx_br_en = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      mon_on = 1'b1;

      // 2: TX D=4
      write_cfg(16'h040);
      base = cyc; tx_br_en = 1'b1;
      tx_q.push_back(base + 64); tx_q.push_back(base + 128); tx_q.push_back(base + 192);
      repeat (200) @(negedge clk);
      tx_br_en = 1'b0;
      settle("t2_tx_d4");

      // 3: RX D=4
      base = cyc; rx_br_en = 1'b1;
      for (int i = 1; i <= 40; i++) rxos_q.push_back(base + 4 * i);
      rxbr_q.push_back(base + 32); rxbr_q.push_back(base + 96); rxbr_q.push_back(base + 160);
      repeat (162) @(negedge clk);
      rx_br_en = 1'b0;
      settle("t3_rx_d4");

      // 4: D=4.5 on both channels together, os periods 4,5,4,5...
      write_cfg(16'h048);
      base = cyc; tx_br_en = 1'b1; rx_br_en = 1'b1;
      for (int n = 1; n <= 10; n++) tx_q.push_back(base + 72 * n);
      t = 0;
      for (int i = 0; t <= 725; i++) begin
         t += (i % 2 == 0) ? 4 : 5;
         if (t <= 725) rxos_q.push_back(base + t);
      end
      for (int n = 0; 36 + 72 * n <= 725; n++) rxbr_q.push_back(base + 36 + 72 * n);
      repeat (725) @(negedge clk);
      tx_br_en = 1'b0; rx_br_en = 1'b0;
      settle("t4_frac");

      // 5a: write 0x080 at edge 40 while running: bit in progress keeps D=4
      write_cfg(16'h040);
      base = cyc; tx_br_en = 1'b1;
      tx_q.push_back(base + 64); tx_q.push_back(base + 192);
      repeat (39) @(negedge clk);
      cfg_div = 16'h080; cfg_we = 1'b1;
      @(negedge clk);
      cfg_we = 1'b0;
      repeat (160) @(negedge clk);
      tx_br_en = 1'b0;
      settle("t5a_live_write");

      // 5b: write while disabled takes effect on the first bit
      write_cfg(16'h040);
      write_cfg(16'h080);
      base = cyc; tx_br_en = 1'b1;
      tx_q.push_back(base + 128); tx_q.push_back(base + 256);
      repeat (260) @(negedge clk);
      tx_br_en = 1'b0;
      settle("t5b_idle_write");

      // 6: drop enable at edge 30, then full period after re-enable
      write_cfg(16'h040);
      tx_br_en = 1'b1;
      repeat (30) @(negedge clk);
      tx_br_en = 1'b0;
      repeat (70) @(negedge clk);
      base = cyc; tx_br_en = 1'b1;
      tx_q.push_back(base + 64);
      repeat (70) @(negedge clk);
      tx_br_en = 1'b0;
      settle("t6_reenable");

      // 6: integer part 1 runs as 2, readback unclamped
      write_cfg(16'h010);
      chk_val("clamp_cfg_div_q", int'(cfg_div_q), 'h010);
      base = cyc; tx_br_en = 1'b1;
      tx_q.push_back(base + 32); tx_q.push_back(base + 64); tx_q.push_back(base + 96);
      repeat (100) @(negedge clk);
      tx_br_en = 1'b0;
      settle("t6_clamp");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
